pipeline_memory_stage: RTL
==========================

Name: pipeline_memory_stage

Overview:
- Parametrised MEM stage of the TSP16 pipeline, between execute and writeback.
- Non-memory instructions pass through in one cycle.
- Loads and stores run a req/ready handshake to a variable-latency data memory, stalling execute until the access completes.
- Valid/ready flow control on both sides; output register holds until writeback accepts it.

Parameters:
- DATA_W, 16, width of result, store data and memory data buses.
- ADDR_W, 16, memory address width; must be <= DATA_W; address is execute_result[ADDR_W-1:0].
- LOAD_OP, 4'b0100, instr[15:12] value decoded as load.
- STORE_OP, 4'b0101, instr[15:12] value decoded as store.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- execute_done  in  1  execute output valid
- execute_ready  out  1  stage can accept this cycle (combinational)
- execute_is_dependent  in  1  dependency flag from execute
- execute_result  in  DATA_W  ALU result / effective address
- execute_store_data  in  DATA_W  store data
- execute_instr  in  16  instruction word
- memory_done  out  1  output valid
- writeback_ready  in  1  writeback accepts output
- memory_is_dependent  out  1  registered dependency flag
- memory_result  out  DATA_W  result to writeback/forwarding
- memory_instr  out  16  instruction word
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_ready  in  1  access complete this cycle
- memory_fault  out  1  sticky timeout flag (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (reset low, asynchronous): every output register 0, state IDLE, mem_req/mem_we/mem_addr/mem_wdata 0, memory_fault 0.
  - A reset mid-access drops mem_req immediately; the memory side must tolerate the aborted request.
- Output handshake:
  - Output is consumed on a clock edge where memory_done && writeback_ready.
  - While memory_done=1 and not consumed, all memory_* outputs are held stable.
- execute_ready = (state==IDLE) && (!memory_done || writeback_ready).
- Accept = execute_done && execute_ready.
- State machine: IDLE, ACCESS.
- IDLE, accept of a non-memory instr:
  - Next edge loads memory_result=execute_result, memory_instr, memory_is_dependent, memory_done=1.
  - Latency 1; back-to-back throughput 1/cycle.
- IDLE, accept of a load/store:
  - Latch instr, dependency flag, address, wdata.
  - mem_req<=1, mem_we<=(STORE_OP), state<=ACCESS.
  - memory_done clears if consumed that edge.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata held stable until an edge with mem_ready=1.
  - On that edge: mem_req<=0, memory_done<=1, memory_result<=mem_rdata (load) or the latched address value (store), state<=IDLE.
  - Minimum load latency 2 cycles accept-to-valid.
- mem_ready while IDLE is ignored.
- Output register is always empty during ACCESS, because accept required it free.
- Simultaneous consume + accept: both occur; memory_done stays 1 with new data (non-mem) or drops to 0 (mem).

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter of ceil(log2(TIMEOUT_CYCLES+1)) bits clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - On reaching TIMEOUT_CYCLES: mem_req<=0, state<=IDLE, memory_done<=1, memory_result<=0, memory_fault<=1.
  - memory_fault is sticky until reset.
- Undefined: no counter; ACCESS waits indefinitely; memory_fault constant 0.

Test Plan:
- Reset low mid-ACCESS with mem_req=1 -> mem_req, memory_done and memory_result read 0 without waiting for a clk edge; state IDLE after release.
- Three back-to-back ADD instrs (execute_result 0x0001, 0x0002, 0x0003), writeback_ready=1 -> memory_result 0x0001/0x0002/0x0003 on consecutive cycles, execute_ready never drops.
- Load at address 0x0040, mem_ready after 3 wait cycles with mem_rdata=0xBEEF -> mem_req high 4 cycles with mem_addr=0x0040 held, execute_ready=0 throughout, then memory_result=0xBEEF, memory_done=1.
- Store, execute_result=0x0010, execute_store_data=0x1234, mem_ready same cycle as first request -> one-cycle mem_req with mem_we=1, mem_wdata=0x1234; memory_done next cycle.
- writeback_ready=0 for 5 cycles after a non-mem result 0x00AA -> memory_result held at 0x00AA, execute_ready=0; releasing with execute_done=1 consumes and accepts on the same edge.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted -> mem_req drops after 8 ACCESS cycles, memory_fault=1 (sticky), memory_done=1, memory_result=0.

Source files
------------

// File: rtl/pipeline_memory_stage_if.sv
// Bundle of execute-side, writeback-side and data-memory-side signals of the MEM stage.
// master = the stage itself, slave = its environment (execute, writeback, memory).
interface pipeline_memory_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  // Handshakes: a transfer happens on a clock edge where valid and ready are both 1
  // (execute_done/execute_ready, memory_done/writeback_ready). A raised valid keeps its
  // payload stable until that edge. mem_req likewise holds mem_we/addr/wdata stable until
  // an edge with mem_ready=1, which completes the access and carries mem_rdata.
  logic              execute_done;
  logic              execute_ready;
  logic              execute_is_dependent;
  logic [DATA_W-1:0] execute_result;
  logic [DATA_W-1:0] execute_store_data;
  logic [15:0]       execute_instr;
  logic              memory_done;
  logic              writeback_ready;
  logic              memory_is_dependent;
  logic [DATA_W-1:0] memory_result;
  logic [15:0]       memory_instr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              memory_fault;

  modport master (
    input  execute_done, execute_is_dependent, execute_result, execute_store_data,
           execute_instr, writeback_ready, mem_rdata, mem_ready,
    output execute_ready, memory_done, memory_is_dependent, memory_result, memory_instr,
           mem_req, mem_we, mem_addr, mem_wdata, memory_fault
  );

  modport slave (
    output execute_done, execute_is_dependent, execute_result, execute_store_data,
           execute_instr, writeback_ready, mem_rdata, mem_ready,
    input  execute_ready, memory_done, memory_is_dependent, memory_result, memory_instr,
           mem_req, mem_we, mem_addr, mem_wdata, memory_fault
  );
endinterface

// File: rtl/pipeline_memory_stage.sv
// TSP16 MEM stage: single-cycle pass-through for ALU ops, blocking handshake for loads/stores.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module pipeline_memory_stage #(
  parameter int          DATA_W         = 16,
  parameter int          ADDR_W         = 16,
  parameter logic [3:0]  LOAD_OP        = 4'b0100,
  parameter logic [3:0]  STORE_OP       = 4'b0101,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_memory_stage_if.master bus,
  output logic                    state_dbg
);

  if (ADDR_W > DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("pipeline_memory_stage: need ADDR_W <= DATA_W and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state, state_n;
  logic              req_q, req_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              is_load_q, is_load_n;
  logic              done_q, done_n;
  logic [DATA_W-1:0] result_q, result_n;
  logic [15:0]       instr_q, instr_n;
  logic              dep_q, dep_n;
  logic              fault_q, fault_n;

  logic              consume, ready, accept, op_load, op_store;
  logic [DATA_W-1:0] addr_ext;

  assign op_load  = (bus.execute_instr[15:12] == LOAD_OP);
  assign op_store = (bus.execute_instr[15:12] == STORE_OP);
  assign consume  = done_q && bus.writeback_ready;
  assign ready    = (state == IDLE) && (!done_q || bus.writeback_ready);
  assign accept   = bus.execute_done && ready;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Clearing while IDLE means the count always starts from zero on entry to ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                cnt_q <= '0;
    else if (state == IDLE)                    cnt_q <= '0;
    else if (!bus.mem_ready && !expired)       cnt_q <= cnt_q + 1'b1;
  end
`endif

  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_W-1:0] = addr_q;
  end

  always_comb begin
    state_n   = state;
    req_n     = req_q;
    we_n      = we_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    is_load_n = is_load_q;
    done_n    = done_q;
    result_n  = result_q;
    instr_n   = instr_q;
    dep_n     = dep_q;
    fault_n   = fault_q;
    case (state)
      IDLE: begin
        if (consume) done_n = 1'b0;
        // Accept implies the output register is free (or being consumed this edge).
        if (accept) begin
          instr_n = bus.execute_instr;
          dep_n   = bus.execute_is_dependent;
          if (op_load || op_store) begin
            addr_n    = bus.execute_result[ADDR_W-1:0];
            wdata_n   = bus.execute_store_data;
            req_n     = 1'b1;
            we_n      = op_store;
            is_load_n = op_load;
            state_n   = ACCESS;
          end else begin
            result_n = bus.execute_result;
            done_n   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          req_n    = 1'b0;
          done_n   = 1'b1;
          result_n = is_load_q ? bus.mem_rdata : addr_ext;
          state_n  = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expired) begin
          req_n    = 1'b0;
          done_n   = 1'b1;
          result_n = '0;
          fault_n  = 1'b1;
          state_n  = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_load_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      instr_q   <= '0;
      dep_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_n;
      req_q     <= req_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      is_load_q <= is_load_n;
      done_q    <= done_n;
      result_q  <= result_n;
      instr_q   <= instr_n;
      dep_q     <= dep_n;
      fault_q   <= fault_n;
    end
  end

  assign bus.execute_ready       = ready;
  assign bus.memory_done         = done_q;
  assign bus.memory_result       = result_q;
  assign bus.memory_instr        = instr_q;
  assign bus.memory_is_dependent = dep_q;
  assign bus.mem_req             = req_q;
  assign bus.mem_we              = we_q;
  assign bus.mem_addr            = addr_q;
  assign bus.mem_wdata           = wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign bus.memory_fault        = fault_q;
`else
  assign bus.memory_fault        = 1'b0;
`endif
  assign state_dbg               = (state == ACCESS);

endmodule
